// File: rtl/snake_input_sequencer.sv
// ============================================================================
// Module   : snake_input_sequencer
// Purpose  : Game-side key sequencer: edge detect, game-mode FSM, step tick
//            and a direction command queue committed one entry per step.
// Options  : INPUT_SYNC_EN - two-flop synchronisers ahead of edge detection
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_input_sequencer #(
    parameter int QUEUE_DEPTH = 4,
    parameter int TICK_DIV    = 2500000,
    parameter int DROP_W      = 8
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          KEY_UP,
    input  logic                          KEY_DOWN,
    input  logic                          KEY_LEFT,
    input  logic                          KEY_RIGHT,
    input  logic                          KEY_S,
    input  logic                          KEY_P,
    input  logic                          KEY_R,
    input  logic                          KEY_ESC,
    input  logic                          COLLIDE,
    output logic                          GAME_TICK,
    output logic [1:0]                    SNDIR,
    output logic [2:0]                    GAME_STATE,
    output logic [$clog2(QUEUE_DEPTH):0]  QUEUE_COUNT,
    output logic [DROP_W-1:0]             DROP_COUNT
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TCK_W = $clog2(TICK_DIV);
    localparam logic [c_TCK_W-1:0] c_TICK_LAST = c_TCK_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_RUN   = 3'b001,
        S_PAUSE = 3'b010,
        S_OVER  = 3'b100
    } state_t;

    // Input bit order: {COLLIDE, ESC, R, P, S, RIGHT, LEFT, DOWN, UP}
    logic [8:0] w_raw;
    logic [8:0] w_in;

    assign w_raw = {COLLIDE, KEY_ESC, KEY_R, KEY_P, KEY_S,
                    KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};

`ifdef INPUT_SYNC_EN
    logic [8:0] sync1_q;
    logic [8:0] sync2_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= w_raw;
            sync2_q <= sync1_q;
        end
    end

    assign w_in = sync2_q;
`else
    assign w_in = w_raw;
`endif

    logic [7:0] key_prev_q;
    logic [7:0] w_ev;
    logic       w_collide;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_prev_q <= '0;
        end else begin
            key_prev_q <= w_in[7:0];
        end
    end

    assign w_ev      = w_in[7:0] & ~key_prev_q;
    assign w_collide = w_in[8];

    logic w_ev_s;
    logic w_ev_p;
    logic w_ev_r;
    logic w_ev_esc;

    assign w_ev_s   = w_ev[4];
    assign w_ev_p   = w_ev[5];
    assign w_ev_r   = w_ev[6];
    assign w_ev_esc = w_ev[7];

    state_t state_q;
    state_t state_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_ev_esc) begin
            state_d = S_IDLE;
        end else if (w_ev_r && (state_q != S_IDLE)) begin
            state_d = S_RUN;
        end else if (w_collide && (state_q == S_RUN)) begin
            state_d = S_OVER;
        end else begin
            case (state_q)
                S_IDLE:  if (w_ev_s) state_d = S_RUN;
                S_RUN:   if (w_ev_p) state_d = S_PAUSE;
                S_PAUSE: if (w_ev_p) state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // A restart or abort empties the queue and blocks this cycle's push/pop.
    logic w_restart;
    logic w_start;
    logic w_flush;
    logic w_act;
    logic w_tick;

    assign w_restart = ~w_ev_esc & w_ev_r & (state_q != S_IDLE);
    assign w_start   = ~w_ev_esc & w_ev_s & (state_q == S_IDLE);
    assign w_flush   = w_ev_esc | w_restart;
    assign w_act     = (state_q == S_RUN) & ~w_flush;

    logic [c_TCK_W-1:0] tick_cnt_q;
    logic [c_TCK_W-1:0] tick_cnt_d;

    assign w_tick    = (state_q == S_RUN) && (tick_cnt_q == c_TICK_LAST);
    assign GAME_TICK = w_tick;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (w_flush) begin
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                S_RUN:   tick_cnt_d = w_tick ? '0 : tick_cnt_q + c_TCK_W'(1);
                S_PAUSE: tick_cnt_d = tick_cnt_q;
                default: tick_cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    logic [1:0]         mem_q [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic [1:0]         sndir_q;
    logic [1:0]         sndir_d;
    logic [DROP_W-1:0]  drop_q;

    logic [1:0] w_cand;
    logic [1:0] w_ref;
    logic       w_dir_any;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;

    always_comb begin
        w_cand = 2'b11;
        if (w_ev[0]) begin
            w_cand = 2'b00;
        end else if (w_ev[1]) begin
            w_cand = 2'b01;
        end else if (w_ev[2]) begin
            w_cand = 2'b10;
        end
    end

    assign w_dir_any = |w_ev[3:0];
    assign w_full    = (count_q == c_FULL);
    assign w_ref     = (count_q != '0) ? mem_q[wr_ptr_q - c_PTR_W'(1)] : sndir_q;
    assign w_pop     = w_act & w_tick & (count_q != '0);
    // Same or opposite direction shares bit 1 (vertical vs horizontal axis).
    assign w_push    = w_act & w_dir_any & (w_cand[1] != w_ref[1]) & (~w_full | w_pop);
    assign w_drop    = w_act & w_dir_any & ~w_push;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_cand;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || w_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        sndir_d = sndir_q;
        if (w_restart || w_start) begin
            sndir_d = 2'b11;
        end else if (w_pop) begin
            sndir_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sndir_q <= 2'b11;
            drop_q  <= '0;
        end else begin
            sndir_q <= sndir_d;
            if (w_drop && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    assign SNDIR       = sndir_q;
    assign GAME_STATE  = state_q;
    assign QUEUE_COUNT = count_q;
    assign DROP_COUNT  = drop_q;

endmodule

`default_nettype wire
